// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request and response bundle for dmem_responder
// master: pipeline side, drives req_valid/req_we/req_addr/req_type/req_wdata.
// slave:  responder side, drives req_ready/rsp_valid/rsp_rdata/rsp_err.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_type;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_type, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_type, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with byte-lane steering and optional wait states
// Parameters: ADDR_WIDTH (word-index bits), WAIT_STATES (0..7 extra cycles per access).
// Ports: clk, rst (async, active-high), bus (dmem_responder_if.slave: request handshake
//        req_valid/req_ready with req_we/req_addr/req_type/req_wdata, response pulse
//        rsp_valid with rsp_rdata/rsp_err).
// Option: DMEM_MISALIGN_TRAP_EN rejects misaligned half/word accesses instead of force-aligning.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);
    localparam logic [2:0] T_WORD  = 3'd0;
    localparam logic [2:0] T_HALF  = 3'd1;
    localparam logic [2:0] T_HALFU = 3'd2;
    localparam logic [2:0] T_BYTE  = 3'd3;
    localparam logic [2:0] T_BYTEU = 3'd4;
    localparam logic [2:0] WS_M1   = 3'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [2:0]              cnt_q;
    logic                    we_q;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic [2:0]              type_q;
    logic [31:0]             wdata_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;
    logic [31:0]             rsp_rdata_q;

    logic [31:0]             mem [2**ADDR_WIDTH];

    logic                    accept;
    logic                    enter_resp;
    logic                    acc_we;
    logic [ADDR_WIDTH+1:0]   acc_addr;
    logic [2:0]              acc_type;
    logic [31:0]             acc_wdata;
    logic                    acc_err;
    logic                    misalign;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [1:0]              lane;
    logic [3:0]              be;
    logic [31:0]             lane_data;
    logic [31:0]             rd_word;
    logic [31:0]             load_data;
    logic                    do_write;

    // Address bits above the array are ignored so the array aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.req_addr[31:ADDR_WIDTH+2], 1'b0};

    assign bus.req_ready = (state_q != ST_WAIT);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_comb begin
        accept     = bus.req_valid & bus.req_ready;
        enter_resp = (accept && (WAIT_STATES == 0)) ||
                     ((state_q == ST_WAIT) && (cnt_q == 3'd0));

        // With zero wait states the access completes on the accept edge itself,
        // so it must use the live request; otherwise it uses the latched copy.
        if (state_q == ST_WAIT) begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_type  = type_q;
            acc_wdata = wdata_q;
        end else begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr[ADDR_WIDTH+1:0];
            acc_type  = bus.req_type;
            acc_wdata = bus.req_wdata;
        end

        idx = acc_addr[ADDR_WIDTH+1:2];

        misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (acc_type == T_WORD && acc_addr[1:0] != 2'b00)
            misalign = 1'b1;
        if ((acc_type == T_HALF || acc_type == T_HALFU) && acc_addr[0])
            misalign = 1'b1;
`endif
        acc_err = (acc_type > T_BYTEU) | misalign;

        lane      = 2'b00;
        be        = 4'b0000;
        lane_data = acc_wdata;
        case (acc_type)
            T_WORD: begin
                lane      = 2'b00;
                be        = 4'b1111;
                lane_data = acc_wdata;
            end
            T_HALF, T_HALFU: begin
                lane      = {acc_addr[1], 1'b0};
                be        = acc_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{acc_wdata[15:0]}};
            end
            T_BYTE, T_BYTEU: begin
                lane      = acc_addr[1:0];
                be        = 4'b0001 << acc_addr[1:0];
                lane_data = {4{acc_wdata[7:0]}};
            end
            default: begin
                lane      = 2'b00;
                be        = 4'b0000;
                lane_data = acc_wdata;
            end
        endcase

        rd_word   = mem[idx];
        load_data = (acc_we || acc_err) ? 32'd0 : (rd_word >> {lane, 3'b000});
        // rst is checked here too so a reset coinciding with the write edge wins.
        do_write  = enter_resp & acc_we & ~acc_err & ~rst;
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            type_q      <= 3'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            rsp_valid_q <= enter_resp;
            rsp_err_q   <= enter_resp & acc_err;
            rsp_rdata_q <= enter_resp ? load_data : 32'd0;

            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr[ADDR_WIDTH+1:0];
                        type_q  <= bus.req_type;
                        wdata_q <= bus.req_wdata;
                        if (WAIT_STATES == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WS_M1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0)
                        state_q <= ST_RESP;
                    else
                        cnt_q <= cnt_q - 3'd1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder: the slave end of the pipeline's load/store port. It accepts one request per handshake from the execute/memory stages, steers the right-justified store data onto the correct byte lanes of a word-organised array, and returns load data shifted back down to bit 0 for the memory stage to sign- or zero-extend. An optional wait-state counter models slow memory, so the pipeline's stall path is exercised with a realistic latency.

## Interface
- ADDR_WIDTH, 10, word-index bits; the array holds 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 0, extra cycles per access, legal range 0..7.

- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_type  input  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned; 101–111 are illegal
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  load data = selected word >> (8*lane offset); 0 for stores and errors
- rsp_err  output  1  request rejected; qualified by rsp_valid

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0.
  - RESP: rsp_valid=1, req_ready=1.
- Accept on a rising edge with req_valid & req_ready. At accept, latch we, addr, type and wdata, then:
  - WAIT_STATES=0: go to RESP.
  - Otherwise: go to WAIT and load counter with WAIT_STATES-1.
- WAIT: decrement the counter each cycle. When counter=0, the next edge goes to RESP.
- RESP: if a new request is accepted, it starts as from IDLE; otherwise go to IDLE.
- Word index = addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so the array wraps around.
- Store lanes:
  - Word: all 4 lanes.
  - Half: lanes {addr[1],0} and {addr[1],1}; data is wdata[15:0].
  - Byte: lane addr[1:0]; data is wdata[7:0].
  - Unselected lanes are unchanged.
- Store type: half unsigned and byte unsigned store identically to half and byte.
- Memory array timing:
  - Store: array write and load read both occur on the edge that enters RESP.
  - Load: a load accepted in the same cycle as a preceding store's RESP sees the stored data.
- Illegal req_type: rsp_err=1, no write, rsp_rdata=0.
- Array contents are not reset.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - rsp_valid 0, rsp_err 0, rsp_rdata 0.
  - req_ready 1, since it is decoded from state.
- Latency: accept edge to rsp_valid high is WAIT_STATES+1 cycles.
- rsp_valid is high for exactly 1 cycle per accepted request.
- Throughput:
  - WAIT_STATES=0: one request per cycle, because back-to-back acceptance is allowed in RESP.
  - Otherwise: one request per WAIT_STATES+1 cycles.
- Request fields are sampled only at accept. Changes while in WAIT are ignored.
- req_valid low in RESP: go to IDLE the next cycle.
- rst asserted mid-WAIT: the pending request is dropped, no write occurs, and no rsp_valid is produced.
- rst asserted during the write edge: rst wins and the write is suppressed.
- All outputs are registered except req_ready.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A half access with addr[0]=1 is rejected with rsp_err=1, no write, rsp_rdata=0.
  - A word access with addr[1:0]≠0 is rejected the same way.
- DMEM_MISALIGN_TRAP_EN undefined:
  - Misaligned addresses are silently force-aligned: half ignores addr[0], word ignores addr[1:0].
  - rsp_err is raised only for an illegal req_type.

## Test plan
- Word round-trip, WAIT_STATES=0:
  - Stimulus: store 0xDEADBEEF at 0x40, then load word at 0x40 back-to-back.
  - Required: the load rsp_valid arrives the cycle after the store response, with rdata=0xDEADBEEF and err=0.
- Lane steering:
  - Stimulus: word-store 0x11223344 at 0x80, byte-store 0xAA at 0x82, half-store 0xBEEF at 0x80, then load word at 0x80.
  - Required: rdata=0x11AABEEF.
- Lane offset on load:
  - Stimulus: word-store 0x8899AABB at 0x10, then load byte unsigned at 0x13.
  - Required: rdata[7:0]=0x88.
  - Stimulus: load half at 0x12.
  - Required: rdata[15:0]=0x8899.
- Misaligned word store of 0x12345678 at 0x21, with 0xCAFEF00D already stored at 0x20:
  - With DMEM_MISALIGN_TRAP_EN: err=1 and memory at 0x20 stays 0xCAFEF00D.
  - Without the macro: err=0 and memory at 0x20 becomes 0x12345678.
- Wait states, WAIT_STATES=3:
  - Stimulus: load at accept edge T.
  - Required: rsp_valid only in cycle T+4, and req_ready=0 in cycles T+1..T+3.
  - Stimulus: req_type=3'b111.
  - Required: err=1 and rdata=0.
- Reset mid-operation, WAIT_STATES=3:
  - Stimulus: store 0x55 at 0x0; assert rst for 1 cycle at T+2.
  - Required: no rsp_valid; req_ready=1 after reset; a subsequent load at 0x0 returns the previous contents.
